// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions (package sys_defs): CDB packet layout and default
// machine widths used by the completion/broadcast logic.
package sys_defs;
  localparam int NUM_CDB_DEF    = 3;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PRF_WIDTH_DEF  = 7;
  localparam int XLEN_DEF       = 32;

  typedef struct packed {
    logic [PRF_WIDTH_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]      data;
    logic                     valid;
  } CDB_PACKET;
endpackage

// File: rtl/cdb_fifo.sv
// Per-channel result buffer: tag/data storage, read/write pointers, occupancy
// count and the ready/drop indications seen by one functional unit.
module cdb_fifo
  import sys_defs::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int TAG_W  = PRF_WIDTH_DEF,
  parameter int DATA_W = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              not_empty,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data,
  output logic              drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic              push, do_pop;

  // Ready deliberately ignores a same-cycle pop: a full buffer stays not-ready.
  assign ready     = count_q < CNT_W'(DEPTH);
  assign not_empty = count_q != '0;
  assign push      = push_valid & ready & ~flush;
  assign do_pop    = pop & not_empty & ~flush;
  assign drop      = push_valid & ~ready;
  assign head_tag  = tag_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q]  <= push_tag;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers per-FU results and broadcasts up to NUM_CDB
// of them per cycle, round-robin across channels, on registered CDB ports.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU     = 7,
  parameter int NUM_CDB    = NUM_CDB_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PRF_WIDTH  = PRF_WIDTH_DEF,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               nuke,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][PRF_WIDTH-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_data,
  output logic [NUM_FU-1:0]                  fu_ready,
  output logic [NUM_CDB-1:0]                 cdb_valid,
  output logic [NUM_CDB-1:0][PRF_WIDTH-1:0]  cdb_tag,
  output logic [NUM_CDB-1:0][XLEN-1:0]       cdb_data,
  output logic                               overflow_err
);
  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int GC_W = $clog2(NUM_CDB + 1);

  logic [NUM_FU-1:0]                not_empty, pop, drop;
  logic [NUM_FU-1:0][PRF_WIDTH-1:0] head_tag;
  logic [NUM_FU-1:0][XLEN-1:0]      head_data;
  CDB_PACKET [NUM_CDB-1:0]          cdb_d, cdb_q;
  logic [RR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                             overflow_err_q, overflow_err_d;
  logic [RR_W:0]                    sum;
  logic [RR_W-1:0]                  chan, last_ch;
  logic [GC_W-1:0]                  gcnt;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .TAG_W (PRF_WIDTH),
      .DATA_W(XLEN)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (nuke),
      .push_valid(fu_valid[i]),
      .push_tag  (fu_tag[i]),
      .push_data (fu_data[i]),
      .pop       (pop[i]),
      .ready     (fu_ready[i]),
      .not_empty (not_empty[i]),
      .head_tag  (head_tag[i]),
      .head_data (head_data[i]),
      .drop      (drop[i])
    );
  end

  // Scan from rr_ptr; the k-th non-empty channel found drives CDB port k.
  always_comb begin
    pop     = '0;
    cdb_d   = '0;
    gcnt    = '0;
    last_ch = '0;
    chan    = '0;
    sum     = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      sum = {1'b0, rr_ptr_q} + (RR_W+1)'(off);
      if (sum >= (RR_W+1)'(NUM_FU)) sum = sum - (RR_W+1)'(NUM_FU);
      chan = sum[RR_W-1:0];
      if (not_empty[chan] && (gcnt < GC_W'(NUM_CDB))) begin
        pop[chan] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (gcnt == GC_W'(k)) begin
            cdb_d[k].valid = 1'b1;
            cdb_d[k].tag   = PRF_WIDTH_DEF'(head_tag[chan]);
            cdb_d[k].data  = XLEN_DEF'(head_data[chan]);
          end
        end
        gcnt    = gcnt + GC_W'(1);
        last_ch = chan;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gcnt != '0)
      rr_ptr_d = (last_ch == RR_W'(NUM_FU - 1)) ? '0 : last_ch + RR_W'(1);
    if (nuke) begin
      rr_ptr_d = '0;
      cdb_d    = '0;
    end
    overflow_err_d = overflow_err_q | (|drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q          <= '0;
      rr_ptr_q       <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      cdb_q          <= cdb_d;
      rr_ptr_q       <= rr_ptr_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_valid[k] = cdb_q[k].valid;
      cdb_tag[k]   = PRF_WIDTH'(cdb_q[k].tag);
      cdb_data[k]  = XLEN'(cdb_q[k].data);
    end
  end

  assign overflow_err = overflow_err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: instance A uses defaults (3 CDB ports),
// instance B a single CDB port so channels can back up.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n, nuke;

  logic [6:0]        a_valid, a_ready, b_valid, b_ready;
  logic [6:0][6:0]   a_tag, b_tag;
  logic [6:0][31:0]  a_data, b_data;
  logic [2:0]        a_cdb_valid;
  logic [2:0][6:0]   a_cdb_tag;
  logic [2:0][31:0]  a_cdb_data;
  logic [0:0]        b_cdb_valid;
  logic [0:0][6:0]   b_cdb_tag;
  logic [0:0][31:0]  b_cdb_data;
  logic              a_ovf, b_ovf;

  logic [38:0] qa[$];
  logic [38:0] qb[$];
  logic [38:0] ea, eb;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter u_a (
    .clk(clk), .rst_n(rst_n), .nuke(nuke),
    .fu_valid(a_valid), .fu_tag(a_tag), .fu_data(a_data), .fu_ready(a_ready),
    .cdb_valid(a_cdb_valid), .cdb_tag(a_cdb_tag), .cdb_data(a_cdb_data),
    .overflow_err(a_ovf)
  );

  cdb_arbiter #(.NUM_CDB(1)) u_b (
    .clk(clk), .rst_n(rst_n), .nuke(nuke),
    .fu_valid(b_valid), .fu_tag(b_tag), .fu_data(b_data), .fu_ready(b_ready),
    .cdb_valid(b_cdb_valid), .cdb_tag(b_cdb_tag), .cdb_data(b_cdb_data),
    .overflow_err(b_ovf)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input int ch, input logic [6:0] t, input logic [31:0] d, input bit exp);
    a_valid[ch] = 1'b1;
    a_tag[ch]   = t;
    a_data[ch]  = d;
    if (exp) qa.push_back({t, d});
  endtask

  task automatic b_drive(input int ch, input logic [6:0] t, input logic [31:0] d, input bit exp);
    b_valid[ch] = 1'b1;
    b_tag[ch]   = t;
    b_data[ch]  = d;
    if (exp) qb.push_back({t, d});
  endtask

  task automatic idle_all();
    a_valid = '0; a_tag = '0; a_data = '0;
    b_valid = '0; b_tag = '0; b_data = '0;
  endtask

  // Scoreboard: every valid CDB port, in port order, must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (a_cdb_valid[k]) begin
          if (qa.size() == 0) check("a_unexpected_valid", 64'(a_cdb_valid[k]), 64'd0);
          else begin
            ea = qa.pop_front();
            check("a_cdb_tag", 64'(a_cdb_tag[k]), 64'(ea[38:32]));
            check("a_cdb_data", 64'(a_cdb_data[k]), 64'(ea[31:0]));
          end
        end else begin
          check("a_idle_port_zero", 64'({a_cdb_tag[k], a_cdb_data[k]}), 64'd0);
        end
      end
      for (int k = 0; k < 1; k++) begin
        if (b_cdb_valid[k]) begin
          if (qb.size() == 0) check("b_unexpected_valid", 64'(b_cdb_valid[k]), 64'd0);
          else begin
            eb = qb.pop_front();
            check("b_cdb_tag", 64'(b_cdb_tag[k]), 64'(eb[38:32]));
            check("b_cdb_data", 64'(b_cdb_data[k]), 64'(eb[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    nuke  = 1'b0;
    idle_all();
    @(posedge clk); #1;
    check("rst_a_valid", 64'(a_cdb_valid), 64'd0);
    check("rst_a_tag", 64'(a_cdb_tag), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'h7f);
    check("rst_b_ready", 64'(b_ready), 64'h7f);
    check("rst_a_ovf", 64'(a_ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(a_ready), 64'h7f);

    // single result on channel 2
    a_drive(2, 7'h15, 32'hDEAD, 1'b1);
    tick(); idle_all();
    check("single_c1_valid", 64'(a_cdb_valid), 64'd0);
    tick();
    check("single_c2_valid", 64'(a_cdb_valid), 64'b001);
    check("single_c2_tag0", 64'(a_cdb_tag[0]), 64'h15);
    check("single_c2_data0", 64'(a_cdb_data[0]), 64'hDEAD);
    check("single_c2_tag12", 64'({a_cdb_tag[2], a_cdb_tag[1]}), 64'd0);
    check("single_c2_data1", 64'(a_cdb_data[1]), 64'd0);
    check("single_c2_data2", 64'(a_cdb_data[2]), 64'd0);
    tick();
    check("single_c3_valid", 64'(a_cdb_valid), 64'd0);

    // nuke returns rr_ptr to 0, then all seven channels contend
    nuke = 1'b1; tick(); nuke = 1'b0; tick();
    for (int i = 0; i < 7; i++) a_drive(i, 7'(8'h20 + i), 32'h1000 + i, 1'b1);
    tick(); idle_all();
    check("cont_c1_valid", 64'(a_cdb_valid), 64'd0);
    tick();
    check("cont_c2_valid", 64'(a_cdb_valid), 64'b111);
    check("cont_c2_tags", 64'(a_cdb_tag), 64'({7'h22, 7'h21, 7'h20}));
    tick();
    check("cont_c3_valid", 64'(a_cdb_valid), 64'b111);
    check("cont_c3_tags", 64'(a_cdb_tag), 64'({7'h25, 7'h24, 7'h23}));
    tick();
    check("cont_c4_valid", 64'(a_cdb_valid), 64'b001);
    check("cont_c4_tag0", 64'(a_cdb_tag[0]), 64'h26);
    tick();
    check("cont_c5_valid", 64'(a_cdb_valid), 64'd0);
    // rr_ptr back at 0: channel 0 must win port 0 over channel 1
    a_drive(0, 7'h2A, 32'h2A2A, 1'b1);
    a_drive(1, 7'h2B, 32'h2B2B, 1'b1);
    tick(); idle_all();
    tick();
    check("rr0_valid", 64'(a_cdb_valid), 64'b011);
    check("rr0_tags", 64'({a_cdb_tag[1], a_cdb_tag[0]}), 64'({7'h2B, 7'h2A}));
    tick();
    check("rr0_after_valid", 64'(a_cdb_valid), 64'd0);

    // 12 back-to-back results on channel 0: pointer wrap
    for (int c = 0; c < 15; c++) begin
      if (c < 12) a_drive(0, 7'(8'h40 + c), 32'hA000 + c, 1'b1);
      else idle_all();
      check("wrap_ready0", 64'(a_ready[0]), 64'd1);
      check("wrap_valid", 64'(a_cdb_valid), (c >= 2 && c < 14) ? 64'd1 : 64'd0);
      tick();
    end
    idle_all();
    check("wrap_queue_drained", 64'(qa.size()), 64'd0);

    // B: buffer 3 on channel 1, then nuke with a valid input
    for (int i = 0; i < 7; i++) b_drive(i, 7'(8'h30 + i), 32'h3000 + i, (i < 3));
    tick(); idle_all();
    b_drive(1, 7'h38, 32'h3838, 1'b0);
    tick();
    b_drive(1, 7'h39, 32'h3939, 1'b0);
    tick();
    b_drive(1, 7'h3A, 32'h3A3A, 1'b0);
    check("nuke_b_ready1_c3", 64'(b_ready[1]), 64'd1);
    tick();
    b_drive(1, 7'h3B, 32'h3B3B, 1'b0);
    nuke = 1'b1;
    check("nuke_b_c4_valid", 64'(b_cdb_valid), 64'd1);
    tick();
    nuke = 1'b0; idle_all();
    check("nuke_b_c5_valid", 64'(b_cdb_valid), 64'd0);
    check("nuke_b_c5_ready", 64'(b_ready), 64'h7f);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("nuke_b_quiet", 64'(b_cdb_valid), 64'd0);
    end
    check("nuke_b_queue_drained", 64'(qb.size()), 64'd0);

    // B: fill channel 4 behind channels 0..3, fifth push overflows
    for (int i = 0; i < 4; i++) b_drive(i, 7'(8'h50 + i), 32'h5000 + i, 1'b1);
    b_drive(4, 7'h60, 32'h6060, 1'b1);
    check("fill_ready4_c0", 64'(b_ready[4]), 64'd1);
    tick(); idle_all();
    b_drive(4, 7'h61, 32'h6161, 1'b1);
    tick();
    b_drive(4, 7'h62, 32'h6262, 1'b1);
    tick();
    check("fill_ready4_c3", 64'(b_ready[4]), 64'd1);
    b_drive(4, 7'h63, 32'h6363, 1'b1);
    tick();
    check("fill_ready4_c4", 64'(b_ready[4]), 64'd0);
    check("fill_ovf_c4", 64'(b_ovf), 64'd0);
    b_drive(4, 7'h64, 32'h6464, 1'b0);
    tick(); idle_all();
    check("fill_ovf_c5", 64'(b_ovf), 64'd1);
    check("fill_a_ovf", 64'(a_ovf), 64'd0);
    repeat (6) tick();
    check("fill_queue_drained", 64'(qb.size()), 64'd0);
    nuke = 1'b1; tick(); nuke = 1'b0;
    check("ovf_survives_nuke", 64'(b_ovf), 64'd1);
    tick();

    // A: reset mid-burst with two entries buffered on channels 5 and 6
    a_drive(3, 7'h70, 32'h7070, 1'b0);
    a_drive(4, 7'h71, 32'h7171, 1'b0);
    tick(); idle_all();
    a_drive(5, 7'h72, 32'h7272, 1'b0);
    a_drive(6, 7'h73, 32'h7373, 1'b0);
    tick(); idle_all();
    check("midrst_pre_valid", 64'(a_cdb_valid), 64'b011);
    check("midrst_pre_tags", 64'({a_cdb_tag[1], a_cdb_tag[0]}), 64'({7'h71, 7'h70}));
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(a_cdb_valid), 64'd0);
    check("midrst_tag", 64'(a_cdb_tag), 64'd0);
    for (int k = 0; k < 3; k++) check("midrst_data", 64'(a_cdb_data[k]), 64'd0);
    check("midrst_ready", 64'(a_ready), 64'h7f);
    check("midrst_b_ovf", 64'(b_ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("midrst_quiet", 64'(a_cdb_valid), 64'd0);
    end
    check("final_qa_empty", 64'(qa.size()), 64'd0);
    check("final_qb_empty", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
